// File: rtl/timer_pkg.sv
// Shared types and default constants for the pattern-triggered delay timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COUNT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int         DEF_PAT_W       = 4;
  localparam logic [3:0] DEF_PATTERN     = 4'b1101;
  localparam int         DEF_DELAY_W     = 4;
  localparam int         DEF_UNIT_CYCLES = 1000;

  // Prescaler width: max(1, ceil(log2(n)))
  function automatic int pre_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Unit prescaler: counts UNIT_CYCLES-1 down to 0 while run is high and
// reports tick in the cycle it sits at 0. While idle it preloads the reload
// value so the first running cycle always starts a full unit.
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int UNIT_CYCLES = DEF_UNIT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int              PRE_W  = pre_width(UNIT_CYCLES);
  localparam logic [PRE_W-1:0] RELOAD = PRE_W'(UNIT_CYCLES - 1);

  logic [PRE_W-1:0] pre_q, pre_d;

  // Next prescaler value and terminal tick
  always_comb begin
    pre_d = RELOAD;
    tick  = 1'b0;
    if (run) begin
      if (pre_q == '0) tick = 1'b1;
      else             pre_d = pre_q - PRE_W'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_q <= '0;
    else          pre_q <= pre_d;
  end

endmodule

// File: rtl/param_fancy_timer.sv
// Pattern-triggered delay timer: hunt for PATTERN in the serial stream,
// load a DELAY_W-bit delay MSB first, count (delay+1) units, then hold done
// until acknowledged. Outputs decode only registered state.
module param_fancy_timer
  import timer_pkg::*;
#(
  parameter int               PAT_W       = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN     = PAT_W'(DEF_PATTERN),
  parameter int               DELAY_W     = DEF_DELAY_W,
  parameter int               UNIT_CYCLES = DEF_UNIT_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data,
  input  logic               ack,
  input  logic               abort,
  output logic [DELAY_W-1:0] count,
  output logic               counting,
  output logic               done
);

  localparam int              LD_W    = $clog2(DELAY_W + 1);
  localparam logic [LD_W-1:0] LD_LAST = LD_W'(DELAY_W - 1);

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d, hist_shift;
  logic [DELAY_W-1:0] delay_q, delay_d, delay_shift;
  logic [DELAY_W-1:0] count_q, count_d;
  logic [LD_W-1:0]    ld_cnt_q, ld_cnt_d;
  logic               tick;

  timer_prescaler #(.UNIT_CYCLES(UNIT_CYCLES)) u_pre (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state_q == ST_COUNT),
    .tick    (tick)
  );

  // Next-state and datapath updates for the four-state controller
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    delay_d     = delay_q;
    count_d     = count_q;
    ld_cnt_d    = ld_cnt_q;
    hist_shift  = {hist_q[PAT_W-2:0], data};
    delay_shift = delay_q << 1;
    delay_shift[0] = data;
    case (state_q)
      ST_SEARCH: begin
        hist_d = hist_shift;
        if (hist_shift == PATTERN) begin
          state_d  = ST_LOAD;
          ld_cnt_d = '0;
          delay_d  = '0;
        end
      end
      ST_LOAD: begin
        delay_d  = delay_shift;
        ld_cnt_d = ld_cnt_q + LD_W'(1);
        if (ld_cnt_q == LD_LAST) begin
          state_d = ST_COUNT;
          count_d = delay_shift;
        end
      end
      ST_COUNT: begin
        // abort wins over a coincident terminal count
        if (abort) begin
          state_d = ST_SEARCH;
          count_d = '0;
          hist_d  = '0;
        end else if (tick) begin
          if (count_q == '0) state_d = ST_DONE;
          else               count_d = count_q - DELAY_W'(1);
        end
      end
      ST_DONE: begin
        if (ack) begin
          state_d = ST_SEARCH;
          hist_d  = '0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_SEARCH;
      hist_q   <= '0;
      delay_q  <= '0;
      count_q  <= '0;
      ld_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      delay_q  <= delay_d;
      count_q  <= count_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  assign count    = count_q;
  assign counting = (state_q == ST_COUNT);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_param_fancy_timer.sv
// Directed bench for param_fancy_timer with UNIT_CYCLES=4.
module tb_param_fancy_timer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       data, ack, abort;
  logic [3:0] count;
  logic       counting, done;

  int tests = 0;
  int errs  = 0;

  always #5 clk = ~clk;

  param_fancy_timer #(.UNIT_CYCLES(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .data     (data),
    .ack      (ack),
    .abort    (abort),
    .count    (count),
    .counting (counting),
    .done     (done)
  );

  typedef struct packed {
    logic       d;
    logic       a;
    logic       ab;
    logic [3:0] c;
    logic       cn;
    logic       dn;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle; return 1 time unit after the edge
  task automatic drive(input logic d, input logic a, input logic ab);
    data  = d;
    ack   = a;
    abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] c, input logic cn, input logic dn);
    chk({nm, ".count"}, 32'(count), 32'(c));
    chk({nm, ".counting"}, 32'(counting), 32'(cn));
    chk({nm, ".done"}, 32'(done), 32'(dn));
  endtask

  // Send 1101 then the 4 delay bits; returns on the first COUNT sample
  task automatic start_run(input logic [3:0] dly);
    logic [3:0] p;
    p = 4'b1101;
    for (int i = 3; i >= 0; i--) drive(p[i], 1'b0, 1'b0);
    for (int i = 3; i >= 0; i--) drive(dly[i], 1'b0, 1'b0);
  endtask

  initial begin
    logic [3:0] p;
    p = 4'b1101;
    reset_n = 1'b0;
    data = 1'b0; ack = 1'b0; abort = 1'b0;
    #12;
    chk_all("reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Overlapping detect 1,1,1,0,1; delay 0; ack/abort held where ignored
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].d, tbl[i].a, tbl[i].ab);
      chk_all($sformatf("vec%0d", i), tbl[i].c, tbl[i].cn, tbl[i].dn);
    end

    // delay=5: 24 counting cycles, 1101 re-sent during COUNT is ignored
    start_run(4'b0101);
    for (int i = 0; i < 24; i++) begin
      if (i > 0) drive(p[3 - (i % 4)], 1'b0, 1'b0);
      chk_all($sformatf("d5_cnt%0d", i), 4'(5 - i / 4), 1'b1, 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0);
    chk_all("d5_done", 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      drive(p[3 - (i % 4)], 1'b0, 1'b0);
      chk($sformatf("d5_hold%0d", i), 32'(done), 32'd1);
    end
    drive(1'b0, 1'b1, 1'b0);
    chk_all("d5_ack", 4'd0, 1'b0, 1'b0);

    // delay=3 with abort on the 10th counting cycle
    start_run(4'b0011);
    for (int i = 1; i < 10; i++) drive(1'b0, 1'b0, 1'b0);
    chk_all("ab_c10", 4'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk_all("ab_next", 4'd0, 1'b0, 1'b0);
    // 1,0,1 would complete 1101 against a stale history
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("ab_idle%0d", i), 32'({counting, done}), 32'd0);
    end
    start_run(4'b0000);
    chk_all("ab_rearm", 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
    chk_all("ab_rearm_done", 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0);

    // asynchronous reset in the middle of COUNT
    start_run(4'b0010);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0);
    chk_all("rst_pre", 4'd1, 1'b1, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all("rst_async", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("rst_idle%0d", i), 32'({count, counting, done}), 32'd0);
    end
    start_run(4'b0000);
    chk_all("rst_rearm", 4'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0);
    chk_all("rst_rearm_done", 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    chk_all("rst_rearm_ack", 4'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule

// File: doc/param_fancy_timer.md
PARAM_FANCY_TIMER -- requirements
Module: param_fancy_timer

Interface
REQ-001 SHALL have parameter PAT_W, default 4, start-pattern length in bits (>=2).
REQ-002 SHALL have parameter PATTERN, default 4'b1101, start pattern of PAT_W bits, MSB received first.
REQ-003 SHALL have parameter DELAY_W, default 4, delay field width in bits (>=1).
REQ-004 SHALL have parameter UNIT_CYCLES, default 1000, clock cycles per delay unit (>=1).
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port data  input  1  serial bit stream, sampled every cycle.
REQ-008 SHALL have port ack  input  1  user acknowledge of done.
REQ-009 SHALL have port abort  input  1  cancels an active count.
REQ-010 SHALL have port count  output  DELAY_W  remaining delay units while counting, else 0.
REQ-011 SHALL have port counting  output  1  high exactly while in COUNT.
REQ-012 SHALL have port done  output  1  high exactly while in DONE.

Function
REQ-013 SHALL implement four states: SEARCH, LOAD, COUNT, DONE.
REQ-014 In SEARCH, SHALL shift data into a PAT_W-bit history and detect PATTERN with overlap (e.g. 1,1,1,0,1 matches 1101).
REQ-015 SHALL enter LOAD on the cycle after the bit that completes PATTERN is sampled.
REQ-016 LOAD SHALL last exactly DELAY_W cycles, capturing data MSB first into delay.
REQ-017 SHALL enter COUNT on the cycle after the last delay bit, with count = delay and prescaler = UNIT_CYCLES-1.
REQ-018 In COUNT, the prescaler SHALL decrement every cycle; when it is 0 it reloads UNIT_CYCLES-1 and count decrements.
REQ-019 SHALL leave COUNT for DONE when count==0 and prescaler==0, so COUNT lasts exactly (delay+1)*UNIT_CYCLES cycles.
REQ-020 count SHALL never wrap below 0; delay==0 gives exactly UNIT_CYCLES counting cycles.
REQ-021 DONE SHALL hold until ack is sampled high, then move to SEARCH on the next cycle with the pattern history cleared.
REQ-022 abort high in COUNT SHALL move to SEARCH next cycle; done is not asserted and history is cleared.
REQ-023 abort and terminal count in the same cycle SHALL resolve as abort.
REQ-024 ack outside DONE, and abort outside COUNT, SHALL be ignored.
REQ-025 data SHALL be ignored for pattern detection outside SEARCH.
REQ-026 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-027 reset_n low SHALL immediately force SEARCH, history=0, delay=0, prescaler=0, count=0, counting=0, done=0.
REQ-028 Reset asserted mid-LOAD/COUNT/DONE SHALL discard all progress; no done is produced.
REQ-029 Reset deassertion SHALL be synchronous to clk (external synchroniser assumed present at top level).

Structure
REQ-030 The state enum typedef and default parameter constants SHALL live in shared package timer_pkg.
REQ-031 The unit prescaler SHALL be a sub-module timer_prescaler (parameter UNIT_CYCLES; ports clk, reset_n, run, tick).
REQ-032 The prescaler counter width SHALL be max(1, ceil(log2(UNIT_CYCLES))).

Verification (UNIT_CYCLES=4, other defaults)
REQ-033 Bench SHALL drive data 1,1,0,1 then 0,1,0,1 -> delay=5, counting for 24 cycles, count 5..0 each held 4 cycles, then done=1 until ack.
REQ-034 Bench SHALL drive data 1,1,1,0,1 then 0,0,0,0 -> overlap detected; counting for exactly 4 cycles with count=0.
REQ-035 Bench SHALL pulse abort on the 10th counting cycle of a delay=3 run -> counting=0 next cycle, done never asserted, a new 1101 is required.
REQ-036 Bench SHALL pull reset_n low mid-COUNT, asynchronously to clk -> all outputs 0 immediately; after release, SEARCH state.
REQ-037 Bench SHALL hold ack high during SEARCH/LOAD/COUNT -> no effect; with ack low in DONE, done SHALL stay high for at least 20 cycles.
REQ-038 Bench SHALL drive 1101 again during COUNT -> it is ignored; the run completes with its original delay.
